// File: rtl/vtg_pkg.sv
// Shared types and constant helpers for the video timing sequencer.
// Holds the run-state encoding and the timing-total / counter-width functions.
package vtg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } vtg_state_e;

    function automatic int unsigned vtg_total(
        input int unsigned act,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return act + fp + sync + bp;
    endfunction

    // A one-position axis still needs a one-bit counter
    function automatic int unsigned vtg_width(input int unsigned total);
        if (total > 32'd1) begin
            return $clog2(total);
        end else begin
            return 32'd1;
        end
    endfunction

endpackage

// File: rtl/vtg_axis_cnt.sv
// Pixel-strobe qualified wrapping counter for one timing axis (h or v).
// tc flags the last position so the caller can chain the next axis.
module vtg_axis_cnt
    import vtg_pkg::*;
#(
    parameter int unsigned TOTAL = 8,
    parameter int unsigned W     = vtg_width(TOTAL)
) (
    input  logic         aclk,
    input  logic         rst,
    input  logic         clr,
    input  logic         ce,
    output logic [W-1:0] cnt,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 32'd1);

    logic [W-1:0] cnt_r;

    // Advance on ce, wrap to zero after the terminal value
    always_ff @(posedge aclk) begin
        if (rst || clr) begin
            cnt_r <= W'(0);
        end else if (ce) begin
            if (cnt_r == LAST) begin
                cnt_r <= W'(0);
            end else begin
                cnt_r <= cnt_r + W'(1);
            end
        end
    end

    assign cnt = cnt_r;
    assign tc  = (cnt_r == LAST);

endmodule

// File: rtl/vtg_sequencer.sv
// Video timing generator: run/stop sequencing, h/v sync and blank decodes,
// frame-start pulse, frame counter and bridge write-error counter.
module vtg_sequencer
    import vtg_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = 1280,
    parameter int unsigned H_FP      = 110,
    parameter int unsigned H_SYNC    = 40,
    parameter int unsigned H_BP      = 220,
    parameter int unsigned V_ACTIVE  = 720,
    parameter int unsigned V_FP      = 5,
    parameter int unsigned V_SYNC    = 5,
    parameter int unsigned V_BP      = 20,
    parameter bit          HSYNC_POL = 1'b1,
    parameter bit          VSYNC_POL = 1'b1
) (
    input  logic        aclk,
    input  logic        rst,
    input  logic        enable,
    input  logic        vtg_ce,
    input  logic        wr_error,
    input  logic        clr_err,
    output logic        vtg_hsync,
    output logic        vtg_vsync,
    output logic        vtg_hblank,
    output logic        vtg_vblank,
    output logic        vtg_act_vid,
    output logic        vtg_fsync,
    output logic        running,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    localparam int unsigned H_TOTAL = vtg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = vtg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HW      = vtg_width(H_TOTAL);
    localparam int unsigned VW      = vtg_width(V_TOTAL);
    // One spare bit so the sync-end bound cannot alias when it equals the total
    localparam int unsigned HX      = HW + 32'd1;
    localparam int unsigned VX      = VW + 32'd1;

    localparam logic [HX-1:0] H_BLK = HX'(H_ACTIVE);
    localparam logic [HX-1:0] H_SS  = HX'(H_ACTIVE + H_FP);
    localparam logic [HX-1:0] H_SE  = HX'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VX-1:0] V_BLK = VX'(V_ACTIVE);
    localparam logic [VX-1:0] V_SS  = VX'(V_ACTIVE + V_FP);
    localparam logic [VX-1:0] V_SE  = VX'(V_ACTIVE + V_FP + V_SYNC);

    vtg_state_e  state_r;
    logic        running_r;
    logic        fs_pend_r;
    logic        fsync_r;
    logic        hs_r, vs_r, hb_r, vb_r, av_r;
    logic [15:0] frame_cnt_r;
    logic [15:0] err_cnt_r;
    logic        wr_err_d_r;

    logic          adv_s;
    logic          idle_s;
    logic          h_tc_s, v_tc_s;
    logic          frame_wrap_s;
    logic [HW-1:0] hcnt_s;
    logic [VW-1:0] vcnt_s;
    logic [HX-1:0] hx_s;
    logic [VX-1:0] vx_s;
    logic          hb_s, hs_s, vb_s, vs_s;
    logic          err_edge_s;

    assign idle_s       = (state_r == ST_IDLE);
    assign adv_s        = !idle_s && vtg_ce;
    assign frame_wrap_s = adv_s && h_tc_s && v_tc_s;

    vtg_axis_cnt #(.TOTAL(H_TOTAL), .W(HW)) u_hcnt (
        .aclk (aclk),
        .rst  (rst),
        .clr  (idle_s),
        .ce   (adv_s),
        .cnt  (hcnt_s),
        .tc   (h_tc_s)
    );

    vtg_axis_cnt #(.TOTAL(V_TOTAL), .W(VW)) u_vcnt (
        .aclk (aclk),
        .rst  (rst),
        .clr  (idle_s),
        .ce   (adv_s && h_tc_s),
        .cnt  (vcnt_s),
        .tc   (v_tc_s)
    );

    assign hx_s = {1'b0, hcnt_s};
    assign vx_s = {1'b0, vcnt_s};
    assign hb_s = (hx_s >= H_BLK);
    assign hs_s = (hx_s >= H_SS) && (hx_s < H_SE);
    assign vb_s = (vx_s >= V_BLK);
    assign vs_s = (vx_s >= V_SS) && (vx_s < V_SE);

    // Run-state FSM; running and the frame-start pulse are registered with it.
    // A pending frame start is released on the pixel advance that emits pixel (0,0).
    always_ff @(posedge aclk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            running_r <= 1'b0;
            fs_pend_r <= 1'b0;
            fsync_r   <= 1'b0;
        end else begin
            fsync_r   <= fs_pend_r && adv_s;
            fs_pend_r <= (fs_pend_r && !adv_s) ||
                         (frame_wrap_s && ((state_r == ST_RUN) || enable));
            case (state_r)
                ST_IDLE: begin
                    if (enable) begin
                        state_r   <= ST_RUN;
                        running_r <= 1'b1;
                        fs_pend_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state_r <= ST_STOPPING;
                    end
                end
                ST_STOPPING: begin
                    if (enable) begin
                        state_r <= ST_RUN;
                    end else if (frame_wrap_s) begin
                        state_r   <= ST_IDLE;
                        running_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    running_r <= 1'b0;
                    fs_pend_r <= 1'b0;
                end
            endcase
        end
    end

    // Timing outputs follow the counters by one clock and only move on ce
    always_ff @(posedge aclk) begin
        if (rst || idle_s) begin
            hs_r <= ~HSYNC_POL;
            vs_r <= ~VSYNC_POL;
            hb_r <= 1'b0;
            vb_r <= 1'b0;
            av_r <= 1'b0;
        end else if (vtg_ce) begin
            hs_r <= hs_s ? HSYNC_POL : ~HSYNC_POL;
            vs_r <= vs_s ? VSYNC_POL : ~VSYNC_POL;
            hb_r <= hb_s;
            vb_r <= vb_s;
            av_r <= !hb_s && !vb_s;
        end
    end

    // Completed frames, including the one that ends a stop request
    always_ff @(posedge aclk) begin
        if (rst) begin
            frame_cnt_r <= 16'd0;
        end else if (frame_wrap_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end
    end

    assign err_edge_s = wr_error && !wr_err_d_r;

    // Saturating count of write-error rising edges; clear takes priority
    always_ff @(posedge aclk) begin
        if (rst) begin
            wr_err_d_r <= 1'b0;
            err_cnt_r  <= 16'd0;
        end else begin
            wr_err_d_r <= wr_error;
            if (clr_err) begin
                err_cnt_r <= 16'd0;
            end else if (err_edge_s && (err_cnt_r != 16'hFFFF)) begin
                err_cnt_r <= err_cnt_r + 16'd1;
            end
        end
    end

    assign vtg_hsync   = hs_r;
    assign vtg_vsync   = vs_r;
    assign vtg_hblank  = hb_r;
    assign vtg_vblank  = vb_r;
    assign vtg_act_vid = av_r;
    assign vtg_fsync   = fsync_r;
    assign running     = running_r;
    assign frame_cnt   = frame_cnt_r;
    assign err_cnt     = err_cnt_r;

endmodule

// File: tb/tb_vtg_sequencer.sv
// Self-checking bench for vtg_sequencer with a tiny 8x6 raster.
// Per-cycle expectations are queued at drive time and popped after the edge.
module tb_vtg_sequencer;

    logic        aclk = 1'b0;
    logic        rst, enable, vtg_ce, wr_error, clr_err;
    logic        vtg_hsync, vtg_vsync, vtg_hblank, vtg_vblank, vtg_act_vid, vtg_fsync;
    logic        running;
    logic [15:0] frame_cnt, err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        logic [22:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];

    vtg_sequencer #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) dut (
        .aclk        (aclk),
        .rst         (rst),
        .enable      (enable),
        .vtg_ce      (vtg_ce),
        .wr_error    (wr_error),
        .clr_err     (clr_err),
        .vtg_hsync   (vtg_hsync),
        .vtg_vsync   (vtg_vsync),
        .vtg_hblank  (vtg_hblank),
        .vtg_vblank  (vtg_vblank),
        .vtg_act_vid (vtg_act_vid),
        .vtg_fsync   (vtg_fsync),
        .running     (running),
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt)
    );

    always #5 aclk = ~aclk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {hsync, vsync, hblank, vblank, act_vid, fsync, running, frame_cnt}
    function automatic logic [22:0] obs_vec();
        return {vtg_hsync, vtg_vsync, vtg_hblank, vtg_vblank, vtg_act_vid,
                vtg_fsync, running, frame_cnt};
    endfunction

    // Expected {hsync, vsync, hblank, vblank, act_vid} for raster pixel index p
    function automatic logic [4:0] pix_exp(input int p);
        int   h, v;
        logic hb, vb;
        h  = p % 8;
        v  = (p / 8) % 6;
        hb = (h >= 4);
        vb = (v >= 3);
        return {(h == 5 || h == 6), (v == 4), hb, vb, (!hb && !vb)};
    endfunction

    task automatic do_reset();
        rst      = 1'b1;
        enable   = 1'b0;
        vtg_ce   = 1'b0;
        wr_error = 1'b0;
        clr_err  = 1'b0;
        @(negedge aclk);
        rst = 1'b0;
    endtask

    // Start from IDLE with enable held; ce constant or high on even cycles only
    task automatic run_frames(input int ncyc, input bit toggle, input string tag);
        int          n;
        int          p;
        int          fc;
        logic [6:0]  tv;
        logic        ce;
        sb_item_t    it;
        n  = 0;
        fc = 0;
        tv = 7'b0000000;
        for (int k = 1; k <= ncyc; k++) begin
            ce     = toggle ? ((k % 2) == 0) : 1'b1;
            enable = 1'b1;
            vtg_ce = ce;
            if (k == 1) begin
                tv = 7'b0000001;
            end else if (ce) begin
                p  = n;
                n++;
                tv = {pix_exp(p), ((p % 48) == 0), 1'b1};
                fc = (p + 1) / 48;
            end else begin
                tv[1] = 1'b0;
            end
            sb_q.push_back('{tag, {tv, 16'(fc)}});
            @(negedge aclk);
            it = sb_q.pop_front();
            check_val(it.tag, 32'(obs_vec()), 32'(it.exp));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int fs_seen;

        rst      = 1'b1;
        enable   = 1'b0;
        vtg_ce   = 1'b0;
        wr_error = 1'b0;
        clr_err  = 1'b0;
        repeat (3) @(negedge aclk);
        check_val("reset_outs", 32'(obs_vec()), 32'd0);
        check_val("reset_err", 32'(err_cnt), 32'd0);
        // Reset must win over enable and ce
        enable = 1'b1;
        vtg_ce = 1'b1;
        @(negedge aclk);
        check_val("reset_over_en", 32'(obs_vec()), 32'd0);
        rst = 1'b0;

        // Continuous ce: fsync at 2, 50, 98; frame_cnt 2 after 96 ce cycles
        run_frames(100, 1'b0, "ce_const");

        // ce toggling: 96-clock frame period, outputs frozen while ce is low
        do_reset();
        check_val("idle_after_rst", 32'(obs_vec()), 32'd0);
        run_frames(200, 1'b1, "ce_toggle");

        // Stop request at hcnt=3, vcnt=1
        do_reset();
        run_frames(12, 1'b0, "pre_stop");
        enable  = 1'b0;
        fs_seen = 0;
        for (int k = 13; k <= 60; k++) begin
            @(negedge aclk);
            if (vtg_fsync) fs_seen++;
            if (k == 13 || k == 48) check_val("stop_running", 32'(running), 32'd1);
            if (k == 49) begin
                check_val("stop_idle", 32'(running), 32'd0);
                check_val("stop_fcnt", 32'(frame_cnt), 32'd1);
            end
            if (k == 50) check_val("stop_outs", 32'(obs_vec()), 32'(23'd1));
        end
        check_val("stop_no_fsync", 32'(fs_seen), 32'd0);

        // Mid-frame reset at hcnt=6, vcnt=4 of the second frame
        do_reset();
        wr_error = 1'b1;
        @(negedge aclk);
        wr_error = 1'b0;
        @(negedge aclk);
        check_val("pre_rst_err", 32'(err_cnt), 32'd1);
        run_frames(87, 1'b0, "pre_rst");
        rst = 1'b1;
        @(negedge aclk);
        check_val("rst_mid_outs", 32'(obs_vec()), 32'd0);
        check_val("rst_mid_err", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        @(negedge aclk);
        check_val("rst_restart1", 32'(obs_vec()), 32'({7'b0000001, 16'd0}));
        @(negedge aclk);
        check_val("rst_restart2", 32'(obs_vec()), 32'({7'b0000111, 16'd0}));

        // Error edge counting and clear priority
        do_reset();
        for (int i = 0; i < 2; i++) begin
            wr_error = 1'b1;
            @(negedge aclk);
            wr_error = 1'b0;
            @(negedge aclk);
        end
        wr_error = 1'b1;
        repeat (10) @(negedge aclk);
        check_val("err_three", 32'(err_cnt), 32'd3);
        wr_error = 1'b0;
        @(negedge aclk);
        wr_error = 1'b1;
        clr_err  = 1'b1;
        @(negedge aclk);
        check_val("err_clr_wins", 32'(err_cnt), 32'd0);
        clr_err  = 1'b0;
        wr_error = 1'b0;
        @(negedge aclk);
        wr_error = 1'b1;
        @(negedge aclk);
        check_val("err_after_clr", 32'(err_cnt), 32'd1);
        clr_err = 1'b1;
        @(negedge aclk);
        check_val("err_clr_only", 32'(err_cnt), 32'd0);
        clr_err  = 1'b0;
        wr_error = 1'b0;

        // Saturation from 0xFFFE
        force dut.err_cnt_r = 16'hFFFE;
        @(negedge aclk);
        release dut.err_cnt_r;
        @(negedge aclk);
        check_val("err_preset", 32'(err_cnt), 32'h0000FFFE);
        for (int i = 0; i < 3; i++) begin
            wr_error = 1'b1;
            @(negedge aclk);
            if (i == 0) check_val("err_to_max", 32'(err_cnt), 32'h0000FFFF);
            wr_error = 1'b0;
            @(negedge aclk);
        end
        check_val("err_saturate", 32'(err_cnt), 32'h0000FFFF);

        // frame_cnt wraps from 0xFFFF to 0
        do_reset();
        force dut.frame_cnt_r = 16'hFFFF;
        @(negedge aclk);
        release dut.frame_cnt_r;
        enable = 1'b1;
        vtg_ce = 1'b1;
        repeat (48) @(negedge aclk);
        check_val("fcnt_max", 32'(frame_cnt), 32'h0000FFFF);
        @(negedge aclk);
        check_val("fcnt_wrap", 32'(frame_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
